// File: rtl/strange_device_top.sv
// strange_device_top: four-channel digit store with per-channel slot display and edge-detected buttons.
// Next state is formed combinationally so the registered display reflects an event on the same edge.
module strange_device_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  device_choice,
   input  logic [6:0]  digit_choice,
   input  logic        digit_load,
   input  logic        digit_change,
   input  logic        mode_change,
   output logic [31:0] displays_flattened,
   output logic        digit_load_indicator
);
   logic [6:0]  r_mem   [4][4];
   logic [3:0]  r_valid [4];
   logic [1:0]  r_wptr  [4];
   logic [1:0]  r_rptr  [4];
   logic        r_mode, r_prev_load, r_prev_change, r_prev_mode;
   logic [6:0]  w_mem   [4][4];
   logic [3:0]  w_valid [4];
   logic [1:0]  w_wptr  [4];
   logic [1:0]  w_rptr  [4];
   logic [1:0]  w_slot;
   logic [31:0] w_disp;
   logic        w_mode, w_load_ev, w_change_ev, w_mode_ev;

   assign w_load_ev   = digit_load & ~r_prev_load;
   assign w_change_ev = digit_change & ~r_prev_change;
   assign w_mode_ev   = mode_change & ~r_prev_mode;

   // Load uses the pre-toggle mode and the pre-advance rptr
   always_comb begin
      w_mem   = r_mem;
      w_valid = r_valid;
      w_wptr  = r_wptr;
      w_rptr  = r_rptr;
      w_mode  = r_mode ^ w_mode_ev;
      w_slot  = r_mode ? r_rptr[device_choice] : r_wptr[device_choice];
      w_disp  = '0;
      if (w_load_ev) begin
         w_mem[device_choice][w_slot]   = digit_choice;
         w_valid[device_choice][w_slot] = 1'b1;
         if (!r_mode) w_wptr[device_choice] = r_wptr[device_choice] + 2'd1;
      end
      if (w_change_ev) w_rptr[device_choice] = r_rptr[device_choice] + 2'd1;
      for (int k = 0; k < 4; k++)
         w_disp[8*k +: 8] = {w_valid[k][w_rptr[k]], w_valid[k][w_rptr[k]] ? w_mem[k][w_rptr[k]] : 7'd0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem                <= '{default: '0};
         r_valid              <= '{default: '0};
         r_wptr               <= '{default: '0};
         r_rptr               <= '{default: '0};
         r_mode               <= 1'b0;
         r_prev_load          <= 1'b0;
         r_prev_change        <= 1'b0;
         r_prev_mode          <= 1'b0;
         displays_flattened   <= '0;
         digit_load_indicator <= 1'b0;
      end else begin
         r_mem                <= w_mem;
         r_valid              <= w_valid;
         r_wptr               <= w_wptr;
         r_rptr               <= w_rptr;
         r_mode               <= w_mode;
         r_prev_load          <= digit_load;
         r_prev_change        <= digit_change;
         r_prev_mode          <= mode_change;
         displays_flattened   <= w_disp;
         digit_load_indicator <= w_load_ev;
      end
   end
endmodule

// File: tb/tb_strange_device_top.sv
// tb_strange_device_top: table-driven vectors plus hand sequences, checked through an expected-value queue.
module tb_strange_device_top;
   logic        clk = 0;
   logic        rst = 1;
   logic [1:0]  device_choice = '0;
   logic [6:0]  digit_choice = '0;
   logic        digit_load = 0, digit_change = 0, mode_change = 0;
   logic [31:0] displays_flattened;
   logic        digit_load_indicator;
   int          checks = 0, failures = 0;

   typedef struct {
      logic        r;
      logic [1:0]  d;
      logic [6:0]  g;
      logic        l, c, m;
      logic [31:0] ed;
      logic        ei;
   } vec_t;
   typedef struct {
      logic [31:0] ed;
      logic        ei;
      string       nm;
   } exp_t;
   vec_t vecs[$];
   exp_t sb[$];

   strange_device_top dut (
      .clk(clk), .rst(rst), .device_choice(device_choice), .digit_choice(digit_choice),
      .digit_load(digit_load), .digit_change(digit_change), .mode_change(mode_change),
      .displays_flattened(displays_flattened), .digit_load_indicator(digit_load_indicator)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [1:0] d, input logic [6:0] g,
                      input logic l, c, m, input logic [31:0] ed, input logic ei);
      vecs.push_back('{r, d, g, l, c, m, ed, ei});
   endtask

   task automatic step(input logic r, input logic [1:0] d, input logic [6:0] g,
                       input logic l, c, m, input logic [31:0] ed, input logic ei, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r; device_choice = d; digit_choice = g;
      digit_load = l; digit_change = c; mode_change = m;
      sb.push_back('{ed, ei, nm});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (displays_flattened !== e.ed) begin
         failures++;
         $display("FAIL %s display got %h expected %h", e.nm, displays_flattened, e.ed);
      end
      checks++;
      if (digit_load_indicator !== e.ei) begin
         failures++;
         $display("FAIL %s indicator got %b expected %b", e.nm, digit_load_indicator, e.ei);
      end
   endtask

   initial begin
      // reset, then one load on channels 0, 1 and 3
      add(1, 0, 0, 0, 0, 0, 32'h0, 0);
      add(1, 0, 0, 0, 0, 0, 32'h0, 0);
      add(0, 0, 1, 1, 0, 0, 32'h0000_0081, 1);
      add(0, 0, 1, 0, 0, 0, 32'h0000_0081, 0);
      add(0, 1, 1, 1, 0, 0, 32'h0000_8181, 1);
      add(0, 1, 1, 0, 0, 0, 32'h0000_8181, 0);
      add(0, 3, 1, 1, 0, 0, 32'h8100_8181, 1);
      add(0, 3, 1, 0, 0, 0, 32'h8100_8181, 0);
      // append with wrap on channel 0, then walk rptr round
      add(1, 0, 0, 0, 0, 0, 32'h0, 0);
      add(0, 0, 1, 1, 0, 0, 32'h81, 1);
      add(0, 0, 1, 0, 0, 0, 32'h81, 0);
      add(0, 0, 2, 1, 0, 0, 32'h81, 1);
      add(0, 0, 2, 0, 0, 0, 32'h81, 0);
      add(0, 0, 3, 1, 0, 0, 32'h81, 1);
      add(0, 0, 3, 0, 0, 0, 32'h81, 0);
      add(0, 0, 4, 1, 0, 0, 32'h81, 1);
      add(0, 0, 4, 0, 0, 0, 32'h81, 0);
      add(0, 0, 5, 1, 0, 0, 32'h85, 1);
      add(0, 0, 5, 0, 0, 0, 32'h85, 0);
      add(0, 0, 0, 0, 1, 0, 32'h82, 0);
      add(0, 0, 0, 0, 0, 0, 32'h82, 0);
      add(0, 0, 0, 0, 1, 0, 32'h83, 0);
      add(0, 0, 0, 0, 0, 0, 32'h83, 0);
      add(0, 0, 0, 0, 1, 0, 32'h84, 0);
      add(0, 0, 0, 0, 0, 0, 32'h84, 0);
      add(0, 0, 0, 0, 1, 0, 32'h85, 0);
      add(0, 0, 0, 0, 0, 0, 32'h85, 0);
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].r, vecs[i].d, vecs[i].g, vecs[i].l, vecs[i].c, vecs[i].m,
              vecs[i].ed, vecs[i].ei, $sformatf("vec%0d", i));

      // held change button advances rptr once (slot1 = 2)
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 32'h82, 0, "held_change");
      step(0, 0, 0, 0, 0, 0, 32'h82, 0, "held_change_rel");
      // held load stores once into slot1 (wptr=1), one indicator pulse
      step(0, 0, 7'h10, 1, 0, 0, 32'h90, 1, "held_load_first");
      for (int i = 0; i < 4; i++) step(0, 0, 7'h10, 1, 0, 0, 32'h90, 0, "held_load_hold");
      step(0, 0, 7'h10, 0, 0, 0, 32'h90, 0, "held_load_rel");

      // edit mode: move rptr to slot2, overwrite it, wptr stays at 2
      step(0, 0, 0, 0, 0, 1, 32'h90, 0, "mode_edit");
      step(0, 0, 0, 0, 0, 0, 32'h90, 0, "mode_edit_rel");
      step(0, 0, 0, 0, 1, 0, 32'h83, 0, "edit_rptr2");
      step(0, 0, 0, 0, 0, 0, 32'h83, 0, "edit_rptr2_rel");
      step(0, 0, 7'h41, 1, 0, 0, 32'hC1, 1, "edit_load");
      step(0, 0, 7'h41, 0, 0, 0, 32'hC1, 0, "edit_load_rel");
      step(0, 0, 0, 0, 0, 1, 32'hC1, 0, "mode_append");
      step(0, 0, 0, 0, 0, 0, 32'hC1, 0, "mode_append_rel");
      step(0, 0, 7'h22, 1, 0, 0, 32'hA2, 1, "append_at_wptr");
      step(0, 0, 7'h22, 0, 0, 0, 32'hA2, 0, "append_at_wptr_rel");

      // edit-mode load+change: slot2 written, display moves to slot3
      step(0, 0, 0, 0, 0, 1, 32'hA2, 0, "mode_edit2");
      step(0, 0, 0, 0, 0, 0, 32'hA2, 0, "mode_edit2_rel");
      step(0, 0, 7'h55, 1, 1, 0, 32'h84, 1, "load_change");
      step(0, 0, 7'h55, 0, 0, 0, 32'h84, 0, "load_change_rel");
      step(0, 0, 0, 0, 1, 0, 32'h85, 0, "walk_slot0");
      step(0, 0, 0, 0, 0, 0, 32'h85, 0, "walk_slot0_rel");
      step(0, 0, 0, 0, 1, 0, 32'h90, 0, "walk_slot1");
      step(0, 0, 0, 0, 0, 0, 32'h90, 0, "walk_slot1_rel");
      step(0, 0, 0, 0, 1, 0, 32'hD5, 0, "walk_slot2");
      step(0, 0, 0, 0, 0, 0, 32'hD5, 0, "walk_slot2_rel");

      // reset while load held: clears, then one append load after release
      step(0, 1, 7'h7F, 1, 0, 0, 32'h0000_FFD5, 1, "pre_reset_load");
      step(1, 1, 7'h7F, 1, 0, 0, 32'h0, 0, "reset_held0");
      step(1, 1, 7'h7F, 1, 0, 0, 32'h0, 0, "reset_held1");
      step(0, 1, 7'h7F, 1, 0, 0, 32'h0000_FF00, 1, "post_reset_load");
      step(0, 1, 7'h7F, 1, 0, 0, 32'h0000_FF00, 0, "post_reset_hold");
      step(0, 1, 7'h7F, 0, 0, 0, 32'h0000_FF00, 0, "post_reset_rel");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/strange_device_top.md
Name:
strange_device_top

Overview:
Four-channel digit-store/display block built around "strange device" style channels. It holds up to four 7-bit digit values per channel and presents each channel's currently selected digit on a packed 32-bit display bus. The 2-bit channel select routes the push-button style inputs (load, change) to one channel. It is the top level driving the board's four display bytes and a load indicator LED.

Parameters:
none (fixed: 4 channels, 4 slots per channel, 7-bit digits, 8-bit display byte per channel)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
device_choice  input  2  selects target channel 0..3 for load/change events
digit_choice  input  7  digit value to store (any 0..127)
digit_load  input  1  button level; rising edge = load event
digit_change  input  1  button level; rising edge = advance displayed slot of selected channel
mode_change  input  1  button level; rising edge = toggle global mode
displays_flattened  output  32  byte k (bits 8k+7:8k) = display of channel k
digit_load_indicator  output  1  one-cycle pulse confirming an accepted load

Behaviour:
- One clock; reset is synchronous and active-high: when rst=1 at a rising clk edge, all state clears.
- Reset values: all mem slots 0, all valid bits 0, all wptr/rptr 0, mode 0, edge-detect history registers 0, displays_flattened 32'h0, digit_load_indicator 0.
- Edge detect: each of digit_load, digit_change and mode_change has a history register (prev). event = in & ~prev, evaluated at each edge. A level held for N cycles gives exactly one event.
- Events act at the same edge where they are detected. Results appear on registered outputs after that edge, i.e. 1 cycle after the input is first sampled high.
- device_choice and digit_choice are sampled at the event edge.
- Per channel c: mem[c][0..3] (7-bit), valid[c][0..3], wptr[c] (2-bit), rptr[c] (2-bit).
- Global mode bit: 0 = append, 1 = edit.
- Load event, mode 0: mem[sel][wptr] <= digit_choice; valid set; wptr increments mod 4. After 3 it wraps to 0 and overwrites the oldest slot.
- Load event, mode 1: mem[sel][rptr] <= digit_choice; valid set; wptr unchanged.
- Change event: rptr[sel] increments mod 4 (3 -> 0). Other channels are unaffected.
- Mode event: mode toggles.
- Display byte k = {valid[k][rptr[k]], valid ? mem[k][rptr[k]] : 7'b0}. It is registered and updates the cycle after any state change.
- digit_load_indicator = 1 for exactly one cycle following each load event, else 0.
- Simultaneous events in the same cycle:
  - Load + change on the same channel in edit mode: write goes to the old rptr, then rptr advances.
  - Load + change in append mode: both apply independently.
  - Mode + load: the load uses the pre-toggle mode.
- Reset mid-operation (including while a button is held): everything clears. A button still held after reset release produces a new event only if prev=0, which it is after reset. So a held level fires once after reset.
- Unselected channels hold state and display unchanged.

Test Plan:
1. Reset: rst=1 for 2 cycles -> displays_flattened=32'h0, digit_load_indicator=0, mode=0.
2. Per-channel load: device_choice=0, digit_choice=7'h01, digit_load high 1 cycle -> byte0=8'h81 and indicator pulses 1 cycle. Then device_choice=1, same load -> byte1=8'h81. Then device_choice=3 -> byte3=8'h81, byte2=8'h00. Final displays_flattened=32'h8100_8181.
3. Append/wrap: channel 0, load 1,2,3,4,5 -> slot0=5 (overwrite), slots1..3=2,3,4. Display shows 8'h85. Then 3 change events -> display 8'h82, 8'h83, 8'h84; a 4th change -> 8'h85.
4. Held button: digit_change held high 10 cycles -> rptr advances exactly once. digit_load held 5 cycles -> one store, one indicator pulse.
5. Edit mode: mode_change pulse, channel 0 rptr at slot 2, load 7'h41 -> byte0=8'hC1 and wptr unchanged. Second mode_change returns to append: the next load writes at wptr.
6. Simultaneous/reset: load+change same cycle in edit mode -> old slot written, display shows next slot. Assert rst while digit_load held -> all cleared, then one load event occurs after rst deasserts.
